// File: rtl/post_process_filter.sv
// post_process_filter: G.729 decoder post-processing, 2nd-order 100 Hz high-pass plus x2 up-scaling.
// Define POST_PROC_SAT_FLAG_EN to add the sticky sat_flag output; the arithmetic is identical either way.
//
// state | meaning
// IDLE  | in_ready high, waiting for a sample
// Y1H   | acc = L_mult(y1_hi, A1)
// Y1L   | acc = L_mac(acc, mult(y1_lo, A1), 1)
// Y2H   | acc = L_add(acc, L_mult(y2_hi, A2))
// Y2L   | acc = L_mac(acc, mult(y2_lo, A2), 1)
// X0    | acc = L_mac(acc, x0, B0)
// X1    | acc = L_mac(acc, x1, B1)
// X2    | acc = L_mac(acc, x2, B2)
// FIN   | scale, shift history, round to out_sample
// DONE  | out_valid held until out_ready
module post_process_filter (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ce,
   input  logic        clr,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_sample,
   output logic        out_valid,
   input  logic        out_ready,
`ifdef POST_PROC_SAT_FLAG_EN
   output logic        sat_flag,
`endif
   output logic [15:0] out_sample
);

   localparam logic signed [15:0] B0    = 16'sd7699;
   localparam logic signed [15:0] B1    = -16'sd15398;
   localparam logic signed [15:0] B2    = 16'sd7699;
   localparam logic signed [15:0] A1    = 16'sd15836;
   localparam logic signed [15:0] A2    = -16'sd7667;
   localparam logic signed [31:0] MAX32 = 32'sh7fff_ffff;
   localparam logic signed [31:0] MIN32 = 32'sh8000_0000;

   typedef enum logic [3:0] {IDLE, Y1H, Y1L, Y2H, Y2L, X0, X1, X2, FIN, DONE} state_t;
   state_t state, state_nxt;

   logic signed [15:0] x0, x1, x2;
   logic signed [31:0] y1, y2, acc;
   logic signed [15:0] mul_a, mul_b, mult_res;
   logic signed [31:0] prod, term, acc_base, acc_nxt, t_val, u_val;
   logic signed [32:0] sum33, rnd33;
   logic               is_mac, lo_op, mult_sat, add_sat, shl2_sat, shl1_sat, rnd_sat;
   logic [15:0]        rnd_val;
   logic               unused_bits;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid) state_nxt = Y1H;
         Y1H:     state_nxt = Y1L;
         Y1L:     state_nxt = Y2H;
         Y2H:     state_nxt = Y2L;
         Y2L:     state_nxt = X0;
         X0:      state_nxt = X1;
         X1:      state_nxt = X2;
         X2:      state_nxt = FIN;
         FIN:     state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else if (ce)
         state <= clr ? IDLE : state_nxt;
   end

   assign in_ready = (state == IDLE);

   // Operand select for the single shared multiplier; lo words are 15-bit L_Extract format
   always_comb begin
      mul_a  = x0;
      mul_b  = B0;
      lo_op  = 1'b0;
      is_mac = 1'b1;
      case (state)
         Y1H:     begin mul_a = y1[31:16];         mul_b = A1; end
         Y1L:     begin mul_a = {1'b0, y1[15:1]};  mul_b = A1; lo_op = 1'b1; end
         Y2H:     begin mul_a = y2[31:16];         mul_b = A2; end
         Y2L:     begin mul_a = {1'b0, y2[15:1]};  mul_b = A2; lo_op = 1'b1; end
         X0:      ;
         X1:      begin mul_a = x1; mul_b = B1; end
         X2:      begin mul_a = x2; mul_b = B2; end
         default: is_mac = 1'b0;
      endcase
   end

   assign prod     = 32'(mul_a) * 32'(mul_b);
   assign mult_sat = (prod == 32'sh4000_0000);
   assign mult_res = mult_sat ? 16'sh7fff : prod[30:15];
   assign term     = lo_op ? {{15{mult_res[15]}}, mult_res, 1'b0}
                           : (mult_sat ? MAX32 : {prod[30:0], 1'b0});
   assign acc_base = (state == Y1H) ? '0 : acc;
   assign sum33    = {acc_base[31], acc_base} + {term[31], term};
   assign add_sat  = sum33[32] ^ sum33[31];
   assign acc_nxt  = add_sat ? (sum33[32] ? MIN32 : MAX32) : sum33[31:0];

   // FIN: t = L_shl(acc,2), then round(L_shl(t,1))
   assign shl2_sat = (acc[31:29] != 3'b000) && (acc[31:29] != 3'b111);
   assign t_val    = shl2_sat ? (acc[31] ? MIN32 : MAX32) : {acc[29:0], 2'b00};
   assign shl1_sat = t_val[31] ^ t_val[30];
   assign u_val    = shl1_sat ? (t_val[31] ? MIN32 : MAX32) : {t_val[30:0], 1'b0};
   assign rnd33    = {u_val[31], u_val} + 33'sh0_0000_8000;
   assign rnd_sat  = rnd33[32] ^ rnd33[31];
   assign rnd_val  = rnd_sat ? 16'h7fff : rnd33[31:16];

   assign unused_bits = ^{rnd33[15:0], y2[0]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x0         <= '0;
         x1         <= '0;
         x2         <= '0;
         y1         <= '0;
         y2         <= '0;
         acc        <= '0;
         out_valid  <= 1'b0;
         out_sample <= '0;
      end else if (ce) begin
         if (clr) begin
            x0        <= '0;
            x1        <= '0;
            x2        <= '0;
            y1        <= '0;
            y2        <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
         end else begin
            if (state == IDLE && in_valid)
               x0 <= in_sample;
            if (is_mac)
               acc <= acc_nxt;
            if (state == FIN) begin
               y2         <= y1;
               y1         <= t_val;
               x2         <= x1;
               x1         <= x0;
               out_sample <= rnd_val;
               out_valid  <= 1'b1;
            end
            if (state == DONE && out_ready)
               out_valid <= 1'b0;
         end
      end
   end

`ifdef POST_PROC_SAT_FLAG_EN
   logic op_sat;
   assign op_sat = (is_mac && (mult_sat || add_sat)) ||
                   (state == FIN && (shl2_sat || shl1_sat || rnd_sat));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         sat_flag <= 1'b0;
      else if (ce) begin
         if (clr)
            sat_flag <= 1'b0;
         else if (op_sat)
            sat_flag <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_post_process_filter.sv
// Self-checking bench for post_process_filter: directed vectors plus random samples
// checked against an ETSI basic-op reference model of the post-processing filter.
module tb_post_process_filter;

   logic               clk, rst_n, ce, clr, in_valid, in_ready, out_valid, out_ready;
   logic signed [15:0] in_sample;
   logic [15:0]        out_sample;
`ifdef POST_PROC_SAT_FLAG_EN
   logic               sat_flag;
`endif

   int errors = 0;
   int checks = 0;

   localparam longint MB0  = 7699;
   localparam longint MB1  = -15398;
   localparam longint MB2  = 7699;
   localparam longint MA1  = 15836;
   localparam longint MA2  = -7667;
   localparam longint MAXL = 64'sd2147483647;
   localparam longint MINL = -64'sd2147483648;

   longint m_x1, m_x2, m_y1, m_y2;
   bit     m_sat;

   post_process_filter dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ce        (ce),
      .clr       (clr),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_sample (in_sample),
      .out_valid (out_valid),
      .out_ready (out_ready),
`ifdef POST_PROC_SAT_FLAG_EN
      .sat_flag  (sat_flag),
`endif
      .out_sample(out_sample)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- reference model (ETSI basic operators on 64-bit integers) ----------------
   function automatic longint sat32(longint v);
      if (v > MAXL) begin m_sat = 1'b1; return MAXL; end
      if (v < MINL) begin m_sat = 1'b1; return MINL; end
      return v;
   endfunction

   function automatic longint l_mult(longint a, longint b);
      return sat32(a * b * 2);
   endfunction

   function automatic longint mult_q(longint a, longint b);
      longint p = (a * b) >>> 15;
      if (p > 32767) begin m_sat = 1'b1; p = 32767; end
      return p;
   endfunction

   function automatic longint l_add(longint a, longint b);
      return sat32(a + b);
   endfunction

   function automatic longint l_shl(longint a, int n);
      return sat32(a * (64'sd1 <<< n));
   endfunction

   function automatic void model_reset();
      m_x1 = 0; m_x2 = 0; m_y1 = 0; m_y2 = 0; m_sat = 1'b0;
   endfunction

   function automatic int model_step(int x);
      longint y1h, y1l, y2h, y2l, acc, t;
      y1h = m_y1 >>> 16;
      y1l = (m_y1 - y1h * 65536) >>> 1;
      y2h = m_y2 >>> 16;
      y2l = (m_y2 - y2h * 65536) >>> 1;
      acc = l_mult(y1h, MA1);
      acc = l_add(acc, l_mult(mult_q(y1l, MA1), 1));
      acc = l_add(acc, l_mult(y2h, MA2));
      acc = l_add(acc, l_mult(mult_q(y2l, MA2), 1));
      acc = l_add(acc, l_mult(longint'(x), MB0));
      acc = l_add(acc, l_mult(m_x1, MB1));
      acc = l_add(acc, l_mult(m_x2, MB2));
      t = l_shl(acc, 2);
      m_y2 = m_y1;
      m_y1 = t;
      m_x2 = m_x1;
      m_x1 = longint'(x);
      return int'(l_add(l_shl(t, 1), 32768) >>> 16);
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic do_clear();
      @(negedge clk);
      ce = 1'b1; in_valid = 1'b0; clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      model_reset();
   endtask

   // Offers one sample with out_ready high; lat counts negedges from the offer until out_valid.
   task automatic run_sample(input int x, output int y, output int lat);
      y = 0;
      lat = -1;
      @(negedge clk);
      ce = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_sample = 16'(x);
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         in_valid = 1'b0;
         if (out_valid === 1'b1) begin
            y = int'($signed(out_sample));
            lat = k;
            break;
         end
      end
      @(negedge clk);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0; ce = 1'b1; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_sample = '0;
      model_reset();
      repeat (3) @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sample !== 16'd0) begin
         errors++;
         $display("FAIL reset_outputs: in_ready=%b out_valid=%b out_sample=%0d, required 1 0 0",
                  in_ready, out_valid, out_sample);
      end
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle_hold: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
      end
`ifdef POST_PROC_SAT_FLAG_EN
      checks++;
      if (sat_flag !== 1'b0) begin
         errors++;
         $display("FAIL reset_sat_flag: got %b, required 0", sat_flag);
      end
`endif
   endtask

   task automatic test_known_vectors();
      int y, lat;
      do_clear();
      run_sample(1000, y, lat);
      checks++;
      if (y !== 1880 || lat !== 9) begin
         errors++;
         $display("FAIL vec_1000: out=%0d lat=%0d, required 1880 lat 9", y, lat);
      end
      run_sample(0, y, lat);
      checks++;
      if (y !== -126 || lat !== 9) begin
         errors++;
         $display("FAIL vec_0_after_1000: out=%0d lat=%0d, required -126 lat 9", y, lat);
      end
   endtask

   task automatic test_saturation();
      int y, lat;
      do_clear();
      run_sample(32767, y, lat);
      checks++;
      if (y !== 32767 || lat !== 9) begin
         errors++;
         $display("FAIL sat_32767: out=%0d lat=%0d, required 32767 lat 9", y, lat);
      end
`ifdef POST_PROC_SAT_FLAG_EN
      checks++;
      if (sat_flag !== 1'b1) begin
         errors++;
         $display("FAIL sat_flag_set: got %b, required 1", sat_flag);
      end
      do_clear();
      checks++;
      if (sat_flag !== 1'b0) begin
         errors++;
         $display("FAIL sat_flag_clr: got %b, required 0", sat_flag);
      end
`endif
   endtask

   task automatic test_backpressure();
      int  exp;
      bit  got;
      do_clear();
      exp = model_step(1000);
      @(negedge clk);
      in_valid = 1'b1; in_sample = 16'sd1000; out_ready = 1'b0;
      got = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         in_valid = 1'b0;
         if (out_valid === 1'b1) begin got = 1'b1; break; end
      end
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL bp_out_valid: out_valid never rose, required 1 within 40 cycles");
      end
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || int'($signed(out_sample)) !== exp) begin
            errors++;
            $display("FAIL bp_hold[%0d]: out_valid=%b in_ready=%b out=%0d, required 1 0 %0d",
                     i, out_valid, in_ready, $signed(out_sample), exp);
         end
      end
      out_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || int'($signed(out_sample)) !== exp) begin
         errors++;
         $display("FAIL bp_release: in_ready=%b out_valid=%b out=%0d, required 1 0 %0d",
                  in_ready, out_valid, $signed(out_sample), exp);
      end
   endtask

   task automatic test_ce_toggle();
      int   exp, seen;
      logic prev_ov, prev_ir;
      do_clear();
      exp = model_step(1000);
      @(negedge clk);
      ce = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_sample = 16'sd1000;
      seen = -1;
      prev_ov = out_valid;
      prev_ir = in_ready;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (k % 2 == 0) begin
            checks++;
            if (out_valid !== prev_ov || in_ready !== prev_ir) begin
               errors++;
               $display("FAIL ce_freeze[%0d]: out_valid=%b in_ready=%b, required %b %b",
                        k, out_valid, in_ready, prev_ov, prev_ir);
            end
         end
         if (out_valid === 1'b1) begin seen = k; break; end
         prev_ov = out_valid;
         prev_ir = in_ready;
         in_valid = 1'b0;
         ce  = (k % 2 == 0);
         clr = (k % 2 == 1);   // a clear while ce is low must be ignored
      end
      clr = 1'b0;
      ce  = 1'b1;
      checks++;
      if (seen !== 17 || int'($signed(out_sample)) !== exp) begin
         errors++;
         $display("FAIL ce_toggle_result: out=%0d seen_at=%0d, required %0d at 17",
                  $signed(out_sample), seen, exp);
      end
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL ce_toggle_release: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
      end
   endtask

   task automatic test_clr_abort();
      int  y, lat;
      bit  spurious;
      do_clear();
      @(negedge clk);
      in_valid = 1'b1; in_sample = 16'sd1000; out_ready = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         in_valid = 1'b0;
      end
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL clr_abort_state: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
      end
      spurious = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (out_valid !== 1'b0) spurious = 1'b1;
      end
      checks++;
      if (spurious) begin
         errors++;
         $display("FAIL clr_abort_no_output: out_valid seen high, required 0");
      end
      model_reset();
      run_sample(1000, y, lat);
      checks++;
      if (y !== model_step(1000) || lat !== 9) begin
         errors++;
         $display("FAIL clr_abort_next: out=%0d lat=%0d, required 1880 lat 9", y, lat);
      end
   endtask

   task automatic test_async_reset_mid();
      int y, lat;
      do_clear();
      @(negedge clk);
      in_valid = 1'b1; in_sample = 16'sd1000; out_ready = 1'b1;
      repeat (4) begin
         @(negedge clk);
         in_valid = 1'b0;
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL async_reset_mid: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
      end
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      run_sample(1000, y, lat);
      checks++;
      if (y !== model_step(1000) || lat !== 9) begin
         errors++;
         $display("FAIL async_reset_next: out=%0d lat=%0d, required 1880 lat 9", y, lat);
      end
   endtask

   task automatic test_random();
      int x, y, lat, exp;
      do_clear();
      for (int n = 0; n < 24; n++) begin
         if ($urandom_range(0, 3) == 0)
            x = int'($signed(16'($urandom)));
         else
            x = int'($urandom_range(0, 4000)) - 2000;
         exp = model_step(x);
         run_sample(x, y, lat);
         checks++;
         if (y !== exp || lat !== 9) begin
            errors++;
            $display("FAIL random[%0d] in=%0d: out=%0d lat=%0d, required %0d lat 9", n, x, y, lat, exp);
         end
`ifdef POST_PROC_SAT_FLAG_EN
         checks++;
         if (sat_flag !== m_sat) begin
            errors++;
            $display("FAIL random_sat_flag[%0d]: got %b, required %b", n, sat_flag, m_sat);
         end
`endif
      end
   endtask

   task automatic test_back_to_back();
      int cur, last_acc, n_out, exp;
      bit will_accept;
      int exp_q[$];
      do_clear();
      out_ready = 1'b1;
      cur = int'($urandom_range(0, 6000)) - 3000;
      last_acc = -1;
      n_out = 0;
      @(negedge clk);
      in_valid = 1'b1; in_sample = 16'(cur);
      for (int c = 0; c < 80; c++) begin
         will_accept = (in_ready === 1'b1);
         if (will_accept) begin
            exp_q.push_back(model_step(cur));
            if (last_acc >= 0) begin
               checks++;
               if (c - last_acc !== 10) begin
                  errors++;
                  $display("FAIL b2b_interval: got %0d cycles, required 10", c - last_acc);
               end
            end
            last_acc = c;
         end
         @(negedge clk);
         if (will_accept) begin
            cur = int'($urandom_range(0, 6000)) - 3000;
            in_sample = 16'(cur);
         end
         if (out_valid === 1'b1) begin
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 99999;
            checks++;
            if (int'($signed(out_sample)) !== exp) begin
               errors++;
               $display("FAIL b2b_out[%0d]: out=%0d, required %0d", n_out, $signed(out_sample), exp);
            end
            n_out++;
            if (n_out == 6) break;
         end
      end
      in_valid = 1'b0;
      checks++;
      if (n_out !== 6) begin
         errors++;
         $display("FAIL b2b_count: got %0d outputs, required 6", n_out);
      end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_known_vectors();
      test_saturation();
      test_backpressure();
      test_ce_toggle();
      test_clr_abort();
      test_async_reset_mid();
      test_random();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
